// File: rtl/n64_response_tx_if.sv
// Handshake and line signals between the fake N64 controller FSM and the joybus transmitter.
interface n64_response_tx_if;
  logic        start;
  logic [2:0]  byte_count;
  logic [31:0] payload;
  logic        drive_low;
  logic        busy;
  logic        done;

  modport master (
    output start, byte_count, payload,
    input  drive_low, busy, done
  );

  modport slave (
    input  start, byte_count, payload,
    output drive_low, busy, done
  );
endinterface

// File: rtl/n64_response_tx.sv
// Joybus response serializer: guard interval, 4-quarter bit cells MSB first, then stop bit.
// Optional line-collision abort is enabled by defining N64_TX_COLLISION_DETECT_EN.
module n64_response_tx #(
  parameter int unsigned CLKS_PER_US = 4,
  parameter int unsigned GUARD_US    = 2
) (
  input  logic sample_clk,
  input  logic reset,
`ifdef N64_TX_COLLISION_DETECT_EN
  input  logic line_in,
  output logic collision,
`endif
  n64_response_tx_if.slave bus
);

  localparam int unsigned QW = $clog2(CLKS_PER_US);
  localparam int unsigned GW = (GUARD_US > 1) ? $clog2(GUARD_US) : 1;
  localparam logic [QW-1:0] QLast = QW'(CLKS_PER_US - 1);
  localparam logic [GW-1:0] GLast = GW'((GUARD_US > 0) ? GUARD_US - 1 : 0);

  typedef enum logic [2:0] {
    StIdle, StGuard, StBitLow, StBitHigh, StStopLow, StStopHigh
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] q_cnt_q, q_cnt_d;
  logic [GW-1:0] g_cnt_q, g_cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   sr_q, sr_d;
  logic          drive_low_q, drive_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          collision_q, collision_d;
  logic          q_last, low_end;
  logic [2:0]    n_bytes;

  always_comb begin
    state_d     = state_q;
    q_cnt_d     = q_cnt_q;
    g_cnt_d     = g_cnt_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    sr_d        = sr_q;
    drive_low_d = drive_low_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    collision_d = 1'b0;
    n_bytes     = 3'd0;

    q_last = (q_cnt_q == QLast);
    // A 1 releases the line after phase 0, a 0 after phase 2.
    low_end = sr_q[31] ? (phase_q == 2'd0) : (phase_q == 2'd2);
    if (state_q != StIdle) begin
      q_cnt_d = q_last ? '0 : q_cnt_q + QW'(1);
    end

    unique case (state_q)
      StIdle: begin
        q_cnt_d = '0;
        if (bus.start && bus.byte_count != 3'd0) begin
          n_bytes   = (bus.byte_count > 3'd4) ? 3'd4 : bus.byte_count;
          sr_d      = bus.payload;
          bit_idx_d = 5'({n_bytes, 3'b000} - 6'd1);
          busy_d    = 1'b1;
          phase_d   = 2'd0;
          g_cnt_d   = '0;
          if (GUARD_US == 0) begin
            state_d     = StBitLow;
            drive_low_d = 1'b1;
          end else begin
            state_d = StGuard;
          end
        end
      end
      StGuard: begin
        if (q_last) begin
          g_cnt_d = g_cnt_q + GW'(1);
          if (g_cnt_q == GLast) begin
            state_d     = StBitLow;
            drive_low_d = 1'b1;
            phase_d     = 2'd0;
          end
        end
      end
      StBitLow: begin
        if (q_last) begin
          phase_d = phase_q + 2'd1;
          if (low_end) begin
            state_d     = StBitHigh;
            drive_low_d = 1'b0;
          end
        end
      end
      StBitHigh: begin
        if (q_last) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            drive_low_d = 1'b1;
            if (bit_idx_q == 5'd0) begin
              state_d = StStopLow;
            end else begin
              state_d   = StBitLow;
              bit_idx_d = bit_idx_q - 5'd1;
              sr_d      = {sr_q[30:0], 1'b0};
            end
          end
        end
      end
      StStopLow: begin
        if (q_last) begin
          state_d     = StStopHigh;
          drive_low_d = 1'b0;
          phase_d     = 2'd0;
        end
      end
      StStopHigh: begin
        if (q_last) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        drive_low_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

`ifdef N64_TX_COLLISION_DETECT_EN
    // Someone else holds the line low while we are releasing it: abandon the frame.
    if ((state_q == StBitHigh || state_q == StStopHigh) && q_last && !line_in) begin
      state_d     = StIdle;
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      collision_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge sample_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      q_cnt_q     <= '0;
      g_cnt_q     <= '0;
      phase_q     <= 2'd0;
      bit_idx_q   <= 5'd0;
      sr_q        <= 32'd0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_cnt_q     <= q_cnt_d;
      g_cnt_q     <= g_cnt_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      sr_q        <= sr_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
    end
  end

  assign bus.drive_low = drive_low_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef N64_TX_COLLISION_DETECT_EN
  assign collision     = collision_q;
`else
  logic unused_collision;
  assign unused_collision = collision_q;
`endif

endmodule

// File: tb/tb_n64_response_tx.sv
// Scoreboard bench for n64_response_tx: a cycle model queues {busy, done, drive_low} per cycle.
module tb_n64_response_tx;
  localparam int Q = 4;
  localparam int G = 8;

  logic sample_clk = 1'b0;
  logic reset      = 1'b0;
`ifdef N64_TX_COLLISION_DETECT_EN
  logic line_in = 1'b1;
  logic collision;
`endif

  n64_response_tx_if bus ();

  n64_response_tx #(
    .CLKS_PER_US(4),
    .GUARD_US   (2)
  ) dut (
    .sample_clk(sample_clk),
    .reset     (reset),
`ifdef N64_TX_COLLISION_DETECT_EN
    .line_in   (line_in),
    .collision (collision),
`endif
    .bus       (bus)
  );

  always #5 sample_clk = ~sample_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Sample order is {busy, done, drive_low}; one entry per negedge.
  task automatic push_n(input logic [2:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back(v);
  endtask

  task automatic push_frame(input int bc, input logic [31:0] pl, input bit lead);
    int nb;
    int lowq;
    nb = (bc > 4) ? 4 : bc;
    if (lead) push_n(3'b000, 1);
    push_n(3'b100, G);
    for (int i = 0; i < 8 * nb; i++) begin
      lowq = pl[31 - i] ? 1 : 3;
      push_n(3'b101, lowq * Q);
      push_n(3'b100, (4 - lowq) * Q);
    end
    push_n(3'b101, Q);
    push_n(3'b100, 2 * Q);
    push_n(3'b010, 1);
  endtask

  always @(negedge sample_clk) begin
    if (sb.size() > 0) begin
      logic [2:0] exp;
      exp = sb.pop_front();
      check_eq("wave", {29'd0, bus.busy, bus.done, bus.drive_low}, {29'd0, exp});
    end
  end

  task automatic wait_drain(input int target, input int max_cycles);
    int cnt;
    cnt = 0;
    while (sb.size() > target && cnt < max_cycles) begin
      @(posedge sample_clk);
      cnt++;
    end
    if (sb.size() > target) begin
      check_eq("timeout", sb.size(), target);
      sb.delete();
    end
  endtask

  task automatic send(input logic [2:0] bc, input logic [31:0] pl);
    @(posedge sample_clk);
    #1;
    bus.start      = 1'b1;
    bus.byte_count = bc;
    bus.payload    = pl;
    if (bc != 3'd0) push_frame(int'(bc), pl, 1'b1);
    else push_n(3'b000, 6);
    @(posedge sample_clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.byte_count = 3'd0;
    bus.payload    = 32'd0;
    repeat (3) @(posedge sample_clk);
    #1;
    check_eq("rst_drive_low", bus.drive_low, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    reset = 1'b1;

    // Single byte, leading 1 then seven 0s.
    send(3'd1, 32'h8000_0000);
    wait_drain(0, 400);

    // Ignored: byte_count of zero.
    send(3'd0, 32'hFFFF_FFFF);
    wait_drain(0, 50);

    // Four bytes, with a mid-frame start and input churn that must not matter.
    send(3'd4, 32'h0500_0002);
    repeat (100) @(posedge sample_clk);
    #1;
    bus.start      = 1'b1;
    bus.payload    = 32'hFFFF_FFFF;
    bus.byte_count = 3'd3;
    @(posedge sample_clk);
    #1;
    bus.start      = 1'b0;
    bus.byte_count = 3'd1;
    bus.payload    = 32'd0;
    wait_drain(0, 1000);

    // Oversized count clamps to four bytes.
    send(3'd7, 32'hC3A5_0F01);
    wait_drain(0, 1000);

    // Back-to-back: second start lands in the done cycle of the first.
    send(3'd1, 32'hA500_0000);
    wait_drain(1, 400);
    #1;
    bus.start      = 1'b1;
    bus.byte_count = 3'd2;
    bus.payload    = 32'h3C96_0000;
    push_frame(2, 32'h3C96_0000, 1'b0);
    @(posedge sample_clk);
    #1;
    bus.start = 1'b0;
    wait_drain(0, 600);

    // Reset mid-frame, while the first cell is low.
    @(posedge sample_clk);
    #1;
    bus.start      = 1'b1;
    bus.byte_count = 3'd1;
    bus.payload    = 32'h0000_0000;
    @(posedge sample_clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge sample_clk);
    #1;
    check_eq("pre_rst_low", bus.drive_low, 1);
    reset = 1'b0;
    #1;
    check_eq("async_rst_low", bus.drive_low, 0);
    check_eq("async_rst_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sample_clk);
      check_eq("rst_no_done", bus.done, 0);
    end
    reset = 1'b1;
    @(posedge sample_clk);
    #1;
    push_n(3'b000, 1 + 20);
    wait_drain(0, 50);

`ifdef N64_TX_COLLISION_DETECT_EN
    // Pull the line low during the high quarter of bit 3 (a 0 bit).
    @(posedge sample_clk);
    #1;
    bus.start      = 1'b1;
    bus.byte_count = 3'd1;
    bus.payload    = 32'h8000_0000;
    @(posedge sample_clk);
    #1;
    bus.start = 1'b0;
    repeat (69) @(posedge sample_clk);
    #1;
    line_in = 1'b0;
    repeat (3) @(posedge sample_clk);
    #1;
    check_eq("coll_pulse", collision, 1);
    check_eq("coll_drive_low", bus.drive_low, 0);
    check_eq("coll_busy", bus.busy, 0);
    check_eq("coll_done", bus.done, 0);
    line_in = 1'b1;
    @(posedge sample_clk);
    #1;
    check_eq("coll_one_cycle", collision, 0);
    push_n(3'b000, 1 + 20);
    wait_drain(0, 50);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/n64_response_tx.md
# n64_response_tx

Serializes the fake N64 controller's response bytes onto the single-wire joybus line. Sits directly downstream of `fake_n64_controller`. After a command is decoded, the controller loads up to four payload bytes and pulses `start`. This block waits a guard interval, then emits each bit as a 4 µs joybus cell followed by the controller stop bit. It drives the open-drain pad enable and reports busy/done back to the controller state machine.

## Interface
Parameters:
- `CLKS_PER_US`, 4: `sample_clk` cycles per 1 µs quarter-cell; must be ≥ 2.
- `GUARD_US`, 2: idle µs between `start` and the first bit; 0 allowed.

Ports:
- `sample_clk` input 1: the one clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to transmit. Sampled only in IDLE.
- `byte_count` input 3: number of payload bytes, 1–4.
- `payload` input 32: response bytes, MSB first. Byte 0 is `[31:24]`.
- `drive_low` output 1: 1 means the pad pulls the data line low; 0 means released (pulled high).
- `busy` output 1: high from the accepting edge until `done`.
- `done` output 1: one-cycle pulse when the stop bit completes.

Reset values: `drive_low`=0, `busy`=0, `done`=0. State returns to IDLE.

## Operation
- States: IDLE, GUARD, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH.
- IDLE:
  - `start`=1 with `byte_count` in 1..4: latch `payload` and `byte_count`, then go to GUARD (or BIT_LOW if `GUARD_US`=0).
  - `byte_count`=0: `start` is ignored and the block stays IDLE.
  - `byte_count` > 4: clamped to 4.
- GUARD: line released for `GUARD_US*CLKS_PER_US` cycles, then BIT_LOW.
- Bit cell: 4 quarters of `CLKS_PER_US` cycles each.
  - Bit 0: 3 quarters low, then 1 quarter high.
  - Bit 1: 1 quarter low, then 3 quarters high.
- Bit order: byte 0 first, MSB first. Total bits = 8×N, where N is the latched count.
- After the last bit: STOP_LOW for 1 quarter, STOP_HIGH for 2 quarters, then `done`=1 and back to IDLE.
- Counters:
  - quarter counter, clog2(`CLKS_PER_US`) bits, wraps at `CLKS_PER_US`-1.
  - phase counter, 2 bits.
  - bit index, 5 bits, counting down from 8N-1.
- `start` while busy is ignored, with no retrigger and no effect on the latched payload.
- Changes to `payload` or `byte_count` after acceptance have no effect.
- Reset mid-frame: `drive_low` goes 0 immediately (asynchronous). There is no `done` pulse, and the frame is abandoned.

## Timing
- Accepting edge k: `busy`=1 registered at edge k.
- The first `drive_low`=1 is registered at edge k + `GUARD_US*CLKS_PER_US`.
- `drive_low` is registered: it has no combinational path from inputs and does not glitch.
- Frame length from the first low edge: (32N + 3)×`CLKS_PER_US` cycles.
- `done` is high for exactly the one cycle following the last STOP_HIGH cycle. `busy` falls on that same edge.
- A new `start` is accepted in the cycle `done` is high, so back-to-back frames are allowed.

## Configuration
- `N64_TX_COLLISION_DETECT_EN` defined:
  - Adds input `line_in` (1 bit, already synchronized).
  - Adds output `collision` (1-cycle pulse).
  - If `line_in`=0 on the last cycle of any BIT_HIGH or STOP_HIGH quarter, the block releases the line, pulses `collision` and returns to IDLE without `done`.
- Undefined: the ports are absent, and the frame always runs to completion.

## Test plan
Test plan assumes `CLKS_PER_US`=4 and `GUARD_US`=2.
- Reset and idle: assert `reset`=0 mid-frame → `drive_low`=0 in the same cycle, `busy`=0, no `done`; after release, IDLE and line high.
- Single byte: `byte_count`=1, `payload`=32'h8000_0000 → 8 idle cycles, then 4 low/12 high, then seven cells of 12 low/4 high, then stop 4 low/8 high. `busy` is high for 148 cycles, then one `done` pulse.
- Four bytes: `payload`=32'h0500_0002 (info response plus pad) → 32 cells matching the bit pattern. Total busy = 8 + 512 + 12 = 532 cycles.
- Ignored requests:
  - `start` with `byte_count`=0 → `busy` stays 0.
  - `start` pulsed mid-frame with a different `payload` → waveform unchanged.
- Back-to-back: `start` asserted in the `done` cycle with `byte_count`=2 → the second frame's guard begins the next cycle.
- With `N64_TX_COLLISION_DETECT_EN`: force `line_in`=0 during the high quarter of bit 3 → `collision` pulse, `drive_low`=0, IDLE, no `done`.
